di_stream_terminal: RTL
=======================

DI_STREAM_TERMINAL -- requirements
Module: di_stream_terminal

Interface
REQ-001 SHALL have parameter TERM_CTRL, default 16'h0010, the di_term_addr value that selects the control register bank.
REQ-002 SHALL have parameter TERM_STREAM, default 16'h0011, the di_term_addr value that selects the stream read port.
REQ-003 SHALL have parameter DEPTH_LOG2, default 9, giving a FIFO depth of 2^DEPTH_LOG2 16-bit words.
REQ-004 SHALL have one clock, ifclk (input, 1), and an asynchronous active-low reset, resetb (input, 1).
REQ-005 SHALL provide the host-side inputs: di_term_addr (16), di_reg_addr (16), di_reg_datai (16), di_read_req (1), di_read (1) and di_write (1).
REQ-006 SHALL provide the host-side outputs: di_reg_datao (16, registered), di_read_rdy (1) and di_write_rdy (1).
REQ-007 SHALL provide the producer-side inputs in_valid (1) and in_data (16); this is a sensor stream with no backpressure.
REQ-008 SHALL provide the outputs fifo_level (DEPTH_LOG2+1) and enable (1), which mirrors CTRL bit 0.

Function
REQ-009 SHALL treat the terminal as selected only when di_term_addr equals TERM_CTRL or TERM_STREAM; when neither is selected, di_read_rdy=0, di_write_rdy=0, and di_write/di_read are ignored.
REQ-010 SHALL implement this CTRL-bank register map:
- 0 CTRL: bit0 enable (rw); bit1 flush (write-1, self-clearing, reads 0).
- 1 STATUS (ro): fifo_level zero-extended to 16 bits.
- 2 OVFL (ro): saturating overflow count; any write clears it.
- 3 SCRATCH (rw).
- Addresses 4..65535 read 16'h0000; writes to them are ignored.
REQ-011 SHALL, when TERM_CTRL is selected, hold di_read_rdy=1 and di_write_rdy=1.
REQ-012 SHALL, when TERM_CTRL is selected, register di_reg_datao every cycle from the current di_reg_addr (1-cycle latency).
REQ-013 SHALL, when TERM_CTRL is selected and di_write=1, write di_reg_datai into register di_reg_addr at that clock edge.
REQ-014 SHALL, for the stream port, ignore di_reg_addr; writes are accepted and discarded with di_write_rdy=1.
REQ-015 SHALL, for the stream port, use a first-word-fall-through output stage: di_reg_datao holds the FIFO head, and a valid flag (ovalid) refills from the FIFO one cycle after it empties.
REQ-016 SHALL, for the stream port, drive di_read_rdy = ovalid & enable.
REQ-017 SHALL, for the stream port, have di_read=1 with ovalid=1 consume the head; the next word is presented the following cycle if the FIFO is non-empty, otherwise ovalid clears.
REQ-018 SHALL have no effect when di_read=1 while ovalid=0: no pop occurs and di_reg_datao is unchanged.
REQ-019 SHALL treat di_read_req as a prefetch hint: with ovalid=0 and the FIFO non-empty, it forces a refill that same cycle; otherwise it has no effect.
REQ-020 SHALL, on in_valid=1 with enable=1 and the FIFO not full, push in_data.
REQ-021 SHALL, on in_valid=1 with enable=1 and the FIFO full, drop the word and increment OVFL, saturating at 16'hFFFF.
REQ-022 SHALL ignore in_valid when enable=0; this is not counted as an overflow.
REQ-023 SHALL, on a simultaneous push and pop, leave fifo_level unchanged.
REQ-024 SHALL count fifo_level from 0 to 2^DEPTH_LOG2, excluding the output-stage word; pointers wrap modulo depth.
REQ-025 SHALL, on a flush, empty the FIFO and clear ovalid in the next cycle; a push in the flush cycle is discarded, and OVFL, SCRATCH and enable are unchanged.
REQ-026 SHALL let a write clearing OVFL take priority over a same-cycle increment.

Reset
REQ-027 SHALL, when resetb=0, asynchronously clear all of the following to 0: di_reg_datao, the FIFO pointers, fifo_level, ovalid, CTRL, OVFL and SCRATCH.
REQ-028 SHALL, during reset, drive di_read_rdy=0, di_write_rdy=0 and enable=0.
REQ-029 SHALL, on reset asserted mid-transfer, discard all buffered data; after release the terminal is idle and disabled.

Configuration
REQ-030 SHALL, with macro DI_STREAM_TERMINAL_OVFL_CNT_EN defined, implement OVFL as specified in REQ-010, REQ-021 and REQ-026.
REQ-031 SHALL, with DI_STREAM_TERMINAL_OVFL_CNT_EN undefined, build no counter: OVFL reads 16'h0000, writes to it are ignored, and dropped words are still dropped.

Structure
REQ-032 SHALL place the register-index constants (CTRL=0, STATUS=1, OVFL=2, SCRATCH=3) and the CTRL bit positions in a shared package, di_terminal_pkg.
REQ-033 SHALL place storage, pointers and the level counter in one sub-module, di_sync_fifo, parameterized by DEPTH_LOG2 with push/pop/flush/full/empty/level ports.
REQ-034 SHALL keep the output stage, register bank and decode in di_stream_terminal.

Verification
REQ-035 SHALL be verified as follows:
- Scratch: select TERM_CTRL, write 16'hA5A5 to addr 3, read addr 3 -> di_reg_datao=16'hA5A5 one cycle after address settles.
- Ordered stream: enable=1, push 16'h0001..16'h0004, select TERM_STREAM, di_read_req pulse, then 4 consecutive di_read -> samples 1,2,3,4; then di_read_rdy=0 and fifo_level=0.
- Overflow (DEPTH_LOG2=2): push 6 words -> fifo_level=4; OVFL=1 or 2 depending on output-stage fill timing, checked exactly; with the macro undefined, OVFL=0.
- Simultaneous push/pop at level 2 for 10 cycles -> level stays 2 and data stays in order.
- Flush: write CTRL=16'h0003 with 3 words buffered -> next cycle fifo_level=0, ovalid=0, di_read_rdy=0, CTRL reads 16'h0001.
- Reset: assert resetb=0 mid-read -> all outputs 0 immediately; after release, SCRATCH=0 and enable=0.

Source files
------------

// File: rtl/di_terminal_pkg.sv
// -----------------------------------------------------------------------------
// di_terminal_pkg
// Shared constants for the DI stream terminal: control-bank register indices,
// CTRL bit positions and the terminal-select encoding used by the decode.
// Optional feature macro (used by di_stream_terminal): DI_STREAM_TERMINAL_OVFL_CNT_EN
// -----------------------------------------------------------------------------
package di_terminal_pkg;

    // Control-bank register indices (di_reg_addr values)
    localparam logic [15:0] REG_CTRL    = 16'd0;
    localparam logic [15:0] REG_STATUS  = 16'd1;
    localparam logic [15:0] REG_OVFL    = 16'd2;
    localparam logic [15:0] REG_SCRATCH = 16'd3;

    // CTRL register bit positions
    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;

    // Which port of the terminal the host is currently addressing
    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_CTRL   = 2'd1,
        SEL_STREAM = 2'd2
    } term_sel_t;

endpackage

// File: rtl/di_sync_fifo.sv
// -----------------------------------------------------------------------------
// di_sync_fifo
// Single-clock FIFO of 2^DEPTH_LOG2 16-bit words. Holds the storage array,
// read/write pointers (wrapping modulo depth) and the occupancy counter.
// Ports:
//   ifclk, resetb        clock, asynchronous active-low reset
//   push, push_data      write one word (ignored when full or flushing)
//   pop                  discard the head word (ignored when empty or flushing)
//   flush                empty the FIFO at this clock edge
//   pop_data             current head word (valid when !empty)
//   full, empty, level   occupancy, level runs 0 .. 2^DEPTH_LOG2
// -----------------------------------------------------------------------------
module di_sync_fifo #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  ifclk,
    input  logic                  resetb,
    input  logic                  push,
    input  logic [15:0]           push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [15:0]           pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    import di_terminal_pkg::*;

    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   level_reg;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (level_reg == FULL_LEVEL);
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign pop_data = mem[rd_ptr_reg];

    // Flush wins over both operations so a flush edge always leaves level 0.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge ifclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_reg <= level_reg + LEVEL_ONE;
            end else if (pop_ok && !push_ok) begin
                level_reg <= level_reg - LEVEL_ONE;
            end
        end
    end

endmodule

// File: rtl/di_stream_terminal.sv
// -----------------------------------------------------------------------------
// di_stream_terminal
// Host-addressable terminal with two addresses: a control register bank
// (TERM_CTRL) and a stream read port (TERM_STREAM) fed by a no-backpressure
// sensor stream through a FIFO plus a first-word-fall-through output stage.
// Optional feature macro: DI_STREAM_TERMINAL_OVFL_CNT_EN builds the
// saturating overflow counter (OVFL register); without it OVFL reads 0.
// Ports:
//   ifclk, resetb                 clock, asynchronous active-low reset
//   di_term_addr, di_reg_addr     terminal select, register index
//   di_reg_datai                  host write data
//   di_read_req, di_read, di_write host strobes
//   di_reg_datao                  registered read data / stream head
//   di_read_rdy, di_write_rdy     host handshakes
//   in_valid, in_data             producer stream
//   fifo_level, enable            FIFO occupancy, CTRL.enable mirror
// -----------------------------------------------------------------------------
module di_stream_terminal #(
    parameter logic [15:0] TERM_CTRL   = 16'h0010,
    parameter logic [15:0] TERM_STREAM = 16'h0011,
    parameter int          DEPTH_LOG2  = 9
) (
    input  logic                ifclk,
    input  logic                resetb,
    input  logic [15:0]         di_term_addr,
    input  logic [15:0]         di_reg_addr,
    input  logic [15:0]         di_reg_datai,
    input  logic                di_read_req,
    input  logic                di_read,
    input  logic                di_write,
    output logic [15:0]         di_reg_datao,
    output logic                di_read_rdy,
    output logic                di_write_rdy,
    input  logic                in_valid,
    input  logic [15:0]         in_data,
    output logic [DEPTH_LOG2:0] fifo_level,
    output logic                enable
);
    import di_terminal_pkg::*;

    term_sel_t   sel;
    logic        ctrl_wr;
    logic        flush;
    logic        consume;
    logic        refill;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_rdata;
    logic [15:0] head_next;
    logic [15:0] reg_rdata;
    logic [15:0] ovfl_value;

    logic        enable_reg;
    logic [15:0] scratch_reg;
    logic        ovalid_reg;
    logic [15:0] head_reg;
    logic [15:0] datao_reg;

    always_comb begin
        sel = SEL_NONE;
        if (di_term_addr == TERM_CTRL) begin
            sel = SEL_CTRL;
        end else if (di_term_addr == TERM_STREAM) begin
            sel = SEL_STREAM;
        end
    end

    assign ctrl_wr = (sel == SEL_CTRL) & di_write;
    assign flush   = ctrl_wr & (di_reg_addr == REG_CTRL) & di_reg_datai[CTRL_FLUSH_BIT];
    assign consume = (sel == SEL_STREAM) & di_read & ovalid_reg;

    // The output stage refills on its own whenever it is empty; di_read_req
    // asks for exactly that, so it only ever coincides with the automatic refill.
    assign refill = ~flush & ~fifo_empty &
                    (~ovalid_reg | consume | ((sel == SEL_STREAM) & di_read_req & ~ovalid_reg));
    assign push   = in_valid & enable_reg & ~fifo_full & ~flush;

    di_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .ifclk     (ifclk),
        .resetb    (resetb),
        .push      (push),
        .push_data (in_data),
        .pop       (refill),
        .flush     (flush),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

`ifdef DI_STREAM_TERMINAL_OVFL_CNT_EN
    logic [15:0] ovfl_reg;
    logic        drop;

    assign drop = in_valid & enable_reg & fifo_full & ~flush;

    // A host write to OVFL clears it even if a word is dropped the same cycle.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            ovfl_reg <= '0;
        end else if (ctrl_wr && (di_reg_addr == REG_OVFL)) begin
            ovfl_reg <= '0;
        end else if (drop && (ovfl_reg != 16'hFFFF)) begin
            ovfl_reg <= ovfl_reg + 16'd1;
        end
    end

    assign ovfl_value = ovfl_reg;
`else
    assign ovfl_value = 16'h0000;
`endif

    always_comb begin
        reg_rdata = 16'h0000;
        case (di_reg_addr)
            REG_CTRL:    reg_rdata = {15'd0, enable_reg};
            REG_STATUS:  reg_rdata = 16'(fifo_level);
            REG_OVFL:    reg_rdata = ovfl_value;
            REG_SCRATCH: reg_rdata = scratch_reg;
            default:     reg_rdata = 16'h0000;
        endcase
    end

    assign head_next = refill ? fifo_rdata : head_reg;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            enable_reg  <= 1'b0;
            scratch_reg <= '0;
            ovalid_reg  <= 1'b0;
            head_reg    <= '0;
            datao_reg   <= '0;
        end else begin
            if (ctrl_wr && (di_reg_addr == REG_CTRL)) begin
                enable_reg <= di_reg_datai[CTRL_ENABLE_BIT];
            end
            if (ctrl_wr && (di_reg_addr == REG_SCRATCH)) begin
                scratch_reg <= di_reg_datai;
            end

            if (flush) begin
                ovalid_reg <= 1'b0;
            end else if (refill) begin
                ovalid_reg <= 1'b1;
            end else if (consume) begin
                ovalid_reg <= 1'b0;
            end
            head_reg <= head_next;

            // Outside the control bank the read data simply tracks the stream head.
            if (sel == SEL_CTRL) begin
                datao_reg <= reg_rdata;
            end else begin
                datao_reg <= head_next;
            end
        end
    end

    assign di_reg_datao = datao_reg;
    assign enable       = enable_reg;
    // Handshakes are held low while reset is asserted, whatever is addressed.
    assign di_write_rdy = resetb & (sel != SEL_NONE);
    assign di_read_rdy  = resetb & ((sel == SEL_CTRL) |
                                    ((sel == SEL_STREAM) & ovalid_reg & enable_reg));

endmodule
